// File: rtl/y86_ctrl_pkg.sv
// Shared definitions for the sequential Y86-64 control path: status codes,
// instruction codes, sequencer state encoding and start-vector bit positions.
package y86_ctrl_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_PCUP   = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;
  localparam int STG_P = 5;

  // Instructions that never touch data memory.
  function automatic logic skips_mem(input logic [3:0] ic);
    return (ic == I_NOP) || (ic == I_RRMOVQ) || (ic == I_IRMOVQ) ||
           (ic == I_OPQ) || (ic == I_JXX);
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage wait counter shared by every stage of the sequencer; flags the
// final permitted wait cycle so the sequencer can halt if no completion came.
module stage_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/y86_stage_sequencer.sv
// Stage sequencer for the sequential Y86-64 core: one instruction at a time
// through F/D/E/M/W/PC. Optional MEM_SKIP_EN lets non-memory icodes bypass MEM.
module y86_stage_sequencer
  import y86_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic             f_com,
  input  logic             d_com,
  input  logic             e_com,
  input  logic             m_com,
  input  logic             w_com,
  input  logic             p_com,
  output logic             f_start,
  output logic             d_start,
  output logic             e_start,
  output logic             m_start,
  output logic             w_start,
  output logic             p_start,
  output logic [2:0]       stat,
  output logic             busy,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  state_e             state_q, state_d;
  logic [5:0]         start_q, start_d;
  logic [2:0]         stat_q, stat_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               entry, com_cur, wd_expired;

  // A start pulse is high exactly in a stage's entry cycle.
  assign entry = |start_q;

  stage_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (entry),
    .enable  (busy && !entry),
    .expired (wd_expired)
  );

`ifdef MEM_SKIP_EN
  logic [3:0] icode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     icode_q <= I_NOP;
    else if (state_q == ST_FETCH && !entry && f_com) icode_q <= icode;
  end
`endif

  always_comb begin
    com_cur = 1'b0;
    case (state_q)
      ST_FETCH:  com_cur = f_com;
      ST_DECODE: com_cur = d_com;
      ST_EXEC:   com_cur = e_com;
      ST_MEM:    com_cur = m_com;
      ST_WB:     com_cur = w_com;
      ST_PCUP:   com_cur = p_com;
      default:   com_cur = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_FETCH;
      ST_HALT: ;
      default: begin
        if (!entry && com_cur) begin
          case (state_q)
            ST_FETCH: begin
              if (imem_error) begin
                state_d = ST_HALT;
                stat_d  = STAT_ADR;
              end else if (!instr_valid) begin
                state_d = ST_HALT;
                stat_d  = STAT_INS;
              end else if (icode == I_HALT) begin
                state_d = ST_HALT;
                stat_d  = STAT_HLT;
              end else begin
                state_d = ST_DECODE;
              end
            end
            ST_DECODE: state_d = ST_EXEC;
`ifdef MEM_SKIP_EN
            ST_EXEC:   state_d = skips_mem(icode_q) ? ST_WB : ST_MEM;
`else
            ST_EXEC:   state_d = ST_MEM;
`endif
            ST_MEM: begin
              if (dmem_error) begin
                state_d = ST_HALT;
                stat_d  = STAT_ADR;
              end else begin
                state_d = ST_WB;
              end
            end
            ST_WB:     state_d = ST_PCUP;
            ST_PCUP: begin
              count_d = count_q + CNT_W'(1);
              state_d = run ? ST_FETCH : ST_IDLE;
            end
            default: ;
          endcase
        end else if (wd_expired) begin
          // Completion on the last permitted cycle wins over the watchdog.
          state_d   = ST_HALT;
          timeout_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    start_d = '0;
    if (state_d != state_q) begin
      case (state_d)
        ST_FETCH:  start_d[STG_F] = 1'b1;
        ST_DECODE: start_d[STG_D] = 1'b1;
        ST_EXEC:   start_d[STG_E] = 1'b1;
        ST_MEM:    start_d[STG_M] = 1'b1;
        ST_WB:     start_d[STG_W] = 1'b1;
        ST_PCUP:   start_d[STG_P] = 1'b1;
        default:   start_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      start_q   <= '0;
      stat_q    <= STAT_AOK;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      stat_q    <= stat_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign f_start     = start_q[STG_F];
  assign d_start     = start_q[STG_D];
  assign e_start     = start_q[STG_E];
  assign m_start     = start_q[STG_M];
  assign w_start     = start_q[STG_W];
  assign p_start     = start_q[STG_P];
  assign stat        = stat_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted      = (state_q == ST_HALT);
  assign timeout     = timeout_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Scoreboard bench for y86_stage_sequencer: expected start pulses are queued
// from a timing model and matched against the pulses the DUT issues.
module tb_y86_stage_sequencer;

  localparam int TMO = 4;
`ifdef MEM_SKIP_EN
  localparam int LEN_OPQ    = 10;
  localparam int LEN_IRMOVQ = 10;
`else
  localparam int LEN_OPQ    = 12;
  localparam int LEN_IRMOVQ = 12;
`endif

  logic        clk, rst_n, run;
  logic [3:0]  icode;
  logic        instr_valid, imem_error, dmem_error;
  logic        f_com, d_com, e_com, m_com, w_com, p_com;
  logic        f_start, d_start, e_start, m_start, w_start, p_start;
  logic [2:0]  stat;
  logic        busy, halted, timeout;
  logic [31:0] instr_count;

  y86_stage_sequencer #(.CNT_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .icode       (icode),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .dmem_error  (dmem_error),
    .f_com       (f_com),
    .d_com       (d_com),
    .e_com       (e_com),
    .m_com       (m_com),
    .w_com       (w_com),
    .p_com       (p_com),
    .f_start     (f_start),
    .d_start     (d_start),
    .e_start     (e_start),
    .m_start     (m_start),
    .w_start     (w_start),
    .p_start     (p_start),
    .stat        (stat),
    .busy        (busy),
    .halted      (halted),
    .timeout     (timeout),
    .instr_count (instr_count)
  );

  typedef struct {
    int stage;
    int cycle;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   delay_cfg[6];
  int   due[6];
  int   cur_stage = 0;
  bit   noise = 0;
  logic [5:0] starts;

  assign starts = {p_start, w_start, m_start, e_start, d_start, f_start};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit tb_skips(input int ic);
`ifdef MEM_SKIP_EN
    return (ic == 1) || (ic == 2) || (ic == 3) || (ic == 6) || (ic == 7);
`else
    return (ic < 0);
`endif
  endfunction

  // Timing model: pushes the expected start pulses for one instruction whose
  // fetch starts at cycle tf; returns the cycle the FSM lands in its next state.
  task automatic model_instr(input int tf, output int te, output int st,
                             output bit hlt, output bit to);
    int  stg[$];
    int  t;
    exp_t e;
    stg = {0, 1, 2};
    if (!tb_skips(int'(icode))) stg.push_back(3);
    stg.push_back(4);
    stg.push_back(5);
    t = tf; st = 1; hlt = 0; to = 0;
    foreach (stg[i]) begin
      e.stage = stg[i];
      e.cycle = t;
      exp_q.push_back(e);
      if (delay_cfg[stg[i]] == 0 || delay_cfg[stg[i]] > TMO) begin
        te = t + TMO + 1; hlt = 1; to = 1;
        return;
      end
      t = t + delay_cfg[stg[i]] + 1;
      if (stg[i] == 0) begin
        if (imem_error)        begin st = 3; hlt = 1; end
        else if (!instr_valid) begin st = 4; hlt = 1; end
        else if (icode == 0)   begin st = 2; hlt = 1; end
        if (hlt) begin te = t; return; end
      end
      if (stg[i] == 3 && dmem_error) begin
        st = 3; hlt = 1; te = t;
        return;
      end
    end
    te = t;
  endtask

  // Monitor and stage responder, both evaluated mid-cycle.
  initial begin
    exp_t e;
    bit   entry_seen;
    logic [5:0] c;
    f_com = 0; d_com = 0; e_com = 0; m_com = 0; w_com = 0; p_com = 0;
    forever begin
      @(negedge clk);
      entry_seen = 0;
      if (starts != 6'd0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start", starts, 6'd0);
        end else begin
          for (int s = 0; s < 6; s++) begin
            if (starts[s]) begin
              e = exp_q.pop_front();
              check("start_stage", s, e.stage);
              check("start_cycle", cyc, e.cycle);
              due[s]     = (delay_cfg[s] > 0) ? cyc + delay_cfg[s] : -1;
              cur_stage  = s;
              entry_seen = 1;
            end
          end
        end
      end
      for (int s = 0; s < 6; s++)
        c[s] = (due[s] == cyc) || (noise && (s != cur_stage)) ||
               (noise && entry_seen && (s == cur_stage));
      {p_com, w_com, m_com, e_com, d_com, f_com} = c;
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic flush();
    exp_q.delete();
    for (int s = 0; s < 6; s++) due[s] = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    run   = 0;
    noise = 0;
    flush();
    for (int s = 0; s < 6; s++) delay_cfg[s] = 1;
    icode = 4'h6; instr_valid = 1; imem_error = 0; dmem_error = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_run(output int t0);
    rst_n = 1;
    run   = 1;
    t0    = cyc;
  endtask

  task automatic run_one(input string tag, input logic [3:0] ic, input bit vld,
                         input bit ierr, input bit derr, input int dly_d,
                         input bit keep_run, input bit nz, input int exp_len);
    int t0, te, st;
    bit hlt, to;
    do_reset();
    icode = ic; instr_valid = vld; imem_error = ierr; dmem_error = derr;
    delay_cfg[1] = dly_d;
    noise = nz;
    release_run(t0);
    model_instr(t0 + 1, te, st, hlt, to);
    wait_cyc(t0 + 2);
    if (!keep_run) run = 0;
    if (exp_len > 0) begin
      wait_cyc(t0 + exp_len);
      check({tag, "_count_before_end"}, instr_count, 0);
      wait_cyc(t0 + 1 + exp_len);
      check({tag, "_count_at_end"}, instr_count, 1);
    end
    wait_cyc(te);
    check({tag, "_stat"},    stat,        st);
    check({tag, "_halted"},  halted,      hlt);
    check({tag, "_timeout"}, timeout,     to);
    check({tag, "_count"},   instr_count, hlt ? 0 : 1);
    check({tag, "_busy"},    busy,        0);
    wait_cyc(te + (keep_run ? 20 : 6));
    check({tag, "_halted_hold"}, halted, hlt);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int t0, te1, te2, tx, st;
    bit hlt, to;

    rst_n = 0; run = 0;
    icode = 4'h6; instr_valid = 1; imem_error = 0; dmem_error = 0;
    for (int s = 0; s < 6; s++) begin delay_cfg[s] = 1; due[s] = -1; end
    repeat (3) @(negedge clk);
    check("rst_starts",  starts,      0);
    check("rst_busy",    busy,        0);
    check("rst_halted",  halted,      0);
    check("rst_timeout", timeout,     0);
    check("rst_stat",    stat,        1);
    check("rst_count",   instr_count, 0);

    // Back-to-back OPq instructions; run drops during EXEC of the second.
    do_reset();
    release_run(t0);
    model_instr(t0 + 1, te1, st, hlt, to);
    model_instr(te1, te2, st, hlt, to);
    wait_cyc(t0 + 1 + LEN_OPQ);
    check("basic_count1", instr_count, 1);
    check("basic_busy",   busy,        1);
    wait_cyc(te1 + 5);
    run = 0;
    wait_cyc(te2);
    check("basic_count2", instr_count, 2);
    check("basic_idle",   busy,        0);
    check("basic_halted", halted,      0);
    check("basic_stat",   stat,        1);
    wait_cyc(te2 + 4);
    check("basic_sb_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of write-back.
    run = 1;
    model_instr(cyc + 1, tx, st, hlt, to);
    for (int i = 0; i < 40 && !w_start; i++) @(negedge clk);
    check("wb_reached", w_start, 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_starts",  starts,      0);
    check("arst_busy",    busy,        0);
    check("arst_halted",  halted,      0);
    check("arst_timeout", timeout,     0);
    check("arst_stat",    stat,        1);
    check("arst_count",   instr_count, 0);
    flush();
    run = 0;

    run_one("halt",      4'h0, 1, 0, 0, 1, 1, 0, 0);
    run_one("adr_ins",   4'h6, 0, 1, 0, 1, 0, 0, 0);
    run_one("ins",       4'h6, 0, 0, 0, 1, 0, 1, 0);
    run_one("dmem",      4'h5, 1, 0, 1, 1, 0, 0, 0);
    run_one("wd_fire",   4'h6, 1, 0, 0, 0, 1, 0, 0);
    run_one("wd_edge",   4'h6, 1, 0, 0, TMO, 0, 1, 0);
    run_one("irmovq",    4'h3, 1, 0, 0, 1, 0, 1, LEN_IRMOVQ);
    run_one("mrmovq",    4'h5, 1, 0, 0, 1, 0, 1, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/y86_stage_sequencer.md
Name: y86_stage_sequencer

Overview:
- Top-level controller for the sequential Y86-64 core.
- Sequences one instruction through the fetch, decode, execute, memory, write-back and PC-update stages, one stage at a time.
- Each stage gets a one-cycle start pulse. The sequencer then waits for that stage's completion flag (f_com, d_com, e_com, m_com, w_com, p_com).
- Tracks processor status and the retired-instruction count, and guards each stage with a watchdog.

Parameters:
- CNT_W, 32, width of instr_count.
- TIMEOUT_CYC, 64, maximum wait cycles per stage before a watchdog halt (must be ≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level; allows a new fetch to begin.
- icode  input  4  instruction code from fetch; valid when f_com=1.
- instr_valid  input  1  fetch decoded a legal icode/ifun; valid when f_com=1.
- imem_error  input  1  fetch address error; valid when f_com=1.
- dmem_error  input  1  data memory address error; valid when m_com=1.
- f_com, d_com, e_com, m_com, w_com, p_com  input  1 each  stage completion flags.
- f_start, d_start, e_start, m_start, w_start, p_start  output  1 each  registered one-cycle stage start pulses.
- stat  output  3  Y86 status: AOK=1, HLT=2, ADR=3, INS=4.
- busy  output  1  high in any stage state.
- halted  output  1  high in HALT.
- timeout  output  1  sticky; set when the watchdog fires.
- instr_count  output  CNT_W  retired instructions.

Behaviour:
- Reset values:
  - FSM in IDLE.
  - All *_start=0, busy=0, halted=0, timeout=0.
  - stat=AOK, instr_count=0.
  - Reset asserted mid-instruction aborts immediately to these values.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUP, HALT.
- IDLE→FETCH when run=1.
- Stage state timing:
  - Entry cycle: the matching *_start is 1 and that stage's com is ignored.
  - Following cycles: the matching com is sampled each cycle. com=1 moves the FSM to the next state on the next edge.
  - Minimum stage time is 2 cycles, so a full instruction takes 12 cycles.
- Only the current stage's com is observed; com flags from other stages are ignored.
- FETCH completion, in priority order:
  1. imem_error=1 → HALT, stat=ADR.
  2. instr_valid=0 → HALT, stat=INS.
  3. icode=0 → HALT, stat=HLT.
  4. Otherwise → DECODE.
- Order after fetch: DECODE→EXEC→MEM→WB→PCUP.
- MEM completion with dmem_error=1 → HALT, stat=ADR; write-back and PC update are skipped.
- PCUP completion:
  - instr_count increments, wrapping modulo 2^CNT_W.
  - Next state is FETCH if run=1, else IDLE.
  - Deasserting run mid-instruction does not abort; the current instruction completes.
- Halting instructions (HLT/ADR/INS faults) do not increment instr_count.
- Watchdog:
  - Counter clears on every stage entry and increments each wait cycle.
  - If no com arrives within TIMEOUT_CYC cycles after the start pulse → HALT, timeout=1, stat unchanged.
  - com arriving on the exact final cycle counts as completion, not timeout.
- HALT is absorbing until rst_n: all starts=0, halted=1, busy=0; stat and instr_count hold.
- stat is written only on entry to HALT.

Optional Feature:
- Macro MEM_SKIP_EN.
- Defined: the icode captured at fetch is held in a register. After EXEC completes, icodes 1, 2, 3, 6, 7 (nop, cmovXX, irmovq, OPq, jXX) go directly to WB. MEM is skipped, no m_start is issued, and dmem_error is never sampled. These instructions take 10 cycles minimum.
- Undefined: every instruction passes through MEM; no icode register is inferred.

Decomposition:
- Package y86_ctrl_pkg:
  - stat codes STAT_AOK/HLT/ADR/INS.
  - icode constants (I_HALT..I_POPQ).
  - FSM state encoding.
- One sub-module, stage_watchdog:
  - Inputs: clk, rst_n, clear, enable.
  - Output: expired.
  - TIMEOUT_CYC parameter.
  - Instantiated once and shared by all stages.

Test Plan:
- Basic sequence: run=1, each com returned 1 cycle after its start, icode=6, valid → starts fire in order f,d,e,m,w,p at cycles 1,3,5,7,9,11. instr_count=1 at cycle 13; f_start again at cycle 13.
- Halt instruction: fetch returns icode=0 → HALT, stat=2, halted=1, instr_count unchanged. No further starts for 20 cycles.
- Fault priority: f_com with imem_error=1 and instr_valid=0 → stat=3 (ADR wins over INS). Separately, MEM completion with dmem_error=1 → stat=3, no w_start, no p_start.
- Watchdog, TIMEOUT_CYC=4:
  - d_com withheld → halted, timeout=1, stat=1, 4 wait cycles after d_start.
  - Repeat with d_com on the 4th wait cycle → proceeds to EXEC, timeout=0.
- Run control and reset: run dropped during EXEC → instruction completes, FSM returns to IDLE, instr_count increments. rst_n pulsed low mid-WB → all outputs return to reset values asynchronously.
- MEM_SKIP_EN defined, icode=3 → no m_start, w_start follows e_com, 10-cycle instruction. icode=5 (mrmovq) still issues m_start.
